// File: rtl/shift_deserializer_if.sv
// Word-side valid/ready handshake between the deserializer and its consumer.
interface shift_deserializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  // Producer side: drives the word and its valid flag
  modport master (output word_out, output word_valid, input word_ready);
  // Consumer side: samples the word and returns ready
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: shifts bits in MSB- or LSB-first, presents each
// completed word on a one-deep valid/ready output, flags dropped words.
module shift_deserializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 msb_first,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun,
  shift_deserializer_if.master wif
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             dir_eff;
  logic             complete;
  logic             drop;

  // Next-state: shift/count, output register load, handshake and overrun
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    word_d   = word_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    drop     = 1'b0;

    // The first bit of a word samples direction; later bits reuse the latch
    dir_eff = (cnt_q == '0) ? msb_first : dir_q;

    if (bit_valid) begin
      dir_d = dir_eff;
      if (dir_eff) sr_d = {sr_q[WIDTH-2:0], bit_in};
      else         sr_d = {bit_in, sr_q[WIDTH-1:1]};
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (valid_q && wif.word_ready) valid_d = 1'b0;

    // A completing word loads only if the slot is empty or being freed now
    if (complete) begin
      if (!valid_q || wif.word_ready) begin
        word_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (clr_overrun) ovr_d = 1'b0;
    if (drop)        ovr_d = 1'b1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wif.word_out   = word_q;
  assign wif.word_valid = valid_q;
  assign busy           = (cnt_q != '0);
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus random
// traffic, compared every cycle against a bit-queue reference model.
module tb_shift_deserializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic msb_first = 1'b0;
  logic clr_overrun = 1'b0;
  logic busy, overrun;

  shift_deserializer_if #(.WIDTH(W)) wif ();

  shift_deserializer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .msb_first  (msb_first),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .wif        (wif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits collected so far, direction of current word, output slot
  bit          m_bits[$];
  bit          m_dir;
  logic [W-1:0] m_word;
  bit          m_valid;
  bit          m_ovr;

  task automatic model_reset();
    m_bits.delete();
    m_dir = 0; m_word = '0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit xfer, complete, drop, nv;
    logic [W-1:0] w;
    xfer = m_valid && wif.word_ready;
    complete = 0; drop = 0; w = '0;
    if (bit_valid) begin
      if (m_bits.size() == 0) m_dir = msb_first;
      m_bits.push_back(bit_in);
      if (m_bits.size() == W) begin
        for (int unsigned i = 0; i < W; i++)
          if (m_bits[i]) w = w + (m_dir ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
        complete = 1;
        m_bits.delete();
      end
    end
    nv = m_valid && !xfer;
    if (complete) begin
      if (!m_valid || wif.word_ready) begin m_word = w; nv = 1; end
      else drop = 1;
    end
    if (drop) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    m_valid = nv;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"},   32'(wif.word_valid), 32'(m_valid));
    check({tag, "_word"},    32'(wif.word_out),   32'(m_word));
    check({tag, "_busy"},    32'(busy),           32'(m_bits.size() != 0));
    check({tag, "_overrun"}, 32'(overrun),        32'(m_ovr));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Send bits first..last of w in the given order, optionally with random gaps;
  // msb_first is flipped after bit index toggle_after (if >= 0)
  task automatic send_bits(input logic [W-1:0] w, input bit msb, input int first,
                           input int last, input bit gaps, input int toggle_after,
                           input string tag);
    logic [W-1:0] wv;
    wv = w;
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        bit_valid = 0;
        for (int k = 0; k < g; k++) step(tag);
      end
      bit_in = msb ? wv[W - 1 - i] : wv[i];
      bit_valid = 1;
      if (i == first && toggle_after < 0) msb_first = msb;
      if (i == 0) msb_first = msb;
      step(tag);
      if (toggle_after >= 0 && i == toggle_after) msb_first = ~msb;
    end
    bit_valid = 0;
  endtask

  initial begin
    model_reset();
    wif.word_ready = 1'b0;
    #1;
    check("rst_valid", 32'(wif.word_valid), 32'd0);
    check("rst_word", 32'(wif.word_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    #20 rst = 1'b0;
    @(negedge clk);

    // MSB-first basic
    wif.word_ready = 1'b1;
    send_bits(16'hA5C3, 1'b1, 0, 15, 1'b0, -1, "t1");
    check("t1_word_const", 32'(wif.word_out), 32'h0000A5C3);
    check("t1_valid_on", 32'(wif.word_valid), 32'd1);
    step("t1_drain");
    check("t1_valid_one_cycle", 32'(wif.word_valid), 32'd0);

    // LSB-first with gaps, direction toggled mid-word
    send_bits(16'h1234, 1'b0, 0, 15, 1'b1, 5, "t2");
    check("t2_word_const", 32'(wif.word_out), 32'h00001234);
    step("t2_drain");

    // Back-pressure hold, then simultaneous completion and transfer
    wif.word_ready = 1'b0;
    send_bits(16'h00FF, 1'b1, 0, 15, 1'b0, -1, "t3a");
    send_bits(16'hFF00, 1'b1, 0, 14, 1'b0, -1, "t3b");
    check("t3_hold_word", 32'(wif.word_out), 32'h000000FF);
    check("t3_hold_valid", 32'(wif.word_valid), 32'd1);
    wif.word_ready = 1'b1;
    send_bits(16'hFF00, 1'b1, 15, 15, 1'b0, -1, "t3c");
    check("t3_swap_word", 32'(wif.word_out), 32'h0000FF00);
    check("t3_swap_valid", 32'(wif.word_valid), 32'd1);
    check("t3_no_ovr", 32'(overrun), 32'd0);
    step("t3_drain");

    // Overrun, clear, then drain the held word
    wif.word_ready = 1'b0;
    send_bits(16'h1111, 1'b1, 0, 15, 1'b0, -1, "t4a");
    send_bits(16'h2222, 1'b1, 0, 15, 1'b0, -1, "t4b");
    check("t4_held_word", 32'(wif.word_out), 32'h00001111);
    check("t4_ovr_set", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    step("t4_clr");
    clr_overrun = 1'b0;
    check("t4_ovr_clr", 32'(overrun), 32'd0);
    wif.word_ready = 1'b1;
    step("t4_xfer");
    check("t4_valid_low", 32'(wif.word_valid), 32'd0);

    // Reset mid-word, asynchronous between edges
    send_bits(16'hBEEF, 1'b1, 0, 8, 1'b0, -1, "t5a");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_valid", 32'(wif.word_valid), 32'd0);
    check("t5_rst_word", 32'(wif.word_out), 32'd0);
    check("t5_rst_ovr", 32'(overrun), 32'd0);
    #1 rst = 1'b0;
    send_bits(16'h0F0F, 1'b1, 0, 15, 1'b0, -1, "t5b");
    check("t5_word_const", 32'(wif.word_out), 32'h00000F0F);
    step("t5_drain");

    // Random traffic against the model
    for (int unsigned c = 0; c < 600; c++) begin
      bit_valid      = 1'($urandom_range(0, 3) != 0);
      bit_in         = 1'($urandom);
      msb_first      = 1'($urandom);
      wif.word_ready = 1'($urandom_range(0, 2) == 0);
      clr_overrun    = 1'($urandom_range(0, 15) == 0);
      step("rnd");
    end
    bit_valid = 0; clr_overrun = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish within limit");
    $fatal(1, "timeout");
  end
endmodule
